rgb2raw_bayer_mosaic: RTL and testbench
=======================================

Name: rgb2raw_bayer_mosaic

Overview:
Re-mosaics a full-RGB pixel stream into a single-channel Bayer raw stream. It is the inverse of the bilinear demosaic on the raw path. Used on the HDR output/loopback path to regenerate sensor-format frames for the demosaic and its verification. It uses the same valid/sop/eop line-streaming interface on both sides.

Parameters:
DATA_WIDTH, 8, bits per colour component and per raw sample
LINE_PIXELS, 1280, expected pixels per line (sop..eop inclusive)
FRAME_LINES, 720, lines per frame; the line counter wraps after this many
BAYER_PATTERN, 0, colour at (line0, col0) / (line0, col1) / (line1, col0) / (line1, col1): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
r_data  in  DATA_WIDTH  red component
g_data  in  DATA_WIDTH  green component
b_data  in  DATA_WIDTH  blue component
rgb_valid  in  1  input pixel valid
rgb_sop  in  1  first pixel of line; qualified by rgb_valid
rgb_eop  in  1  last pixel of line; qualified by rgb_valid
raw_data  out  DATA_WIDTH  Bayer sample
raw_valid  out  1  output valid
raw_sop  out  1  output start of line
raw_eop  out  1  output end of line
sop_err  out  1  one-cycle pulse: sop received inside a line
eop_err  out  1  one-cycle pulse: eop received outside a line
len_err  out  1  one-cycle pulse: line length != LINE_PIXELS
err_cnt  out  16  error counter (see Optional Feature)

Behaviour:
- Reset state: all outputs 0; FSM in S_IDLE; col_cnt=0; line_cnt=0.
- No backpressure. Every accepted pixel produces exactly one output beat.
- Latency is fixed at 1 clk. raw_valid/raw_sop/raw_eop/raw_data register the beat accepted in the previous cycle.
- FSM states:
  - S_IDLE: after reset. Valid beats without sop are dropped. rgb_valid&rgb_sop -> S_LINE.
  - S_LINE: inside a line. Every valid beat is accepted.
    - rgb_valid&rgb_eop -> S_GAP.
    - If sop and eop arrive on the same beat (one-pixel line), stay out of S_LINE: go to S_GAP.
  - S_GAP: between lines. Valid beats without sop are dropped. rgb_valid&rgb_sop -> S_LINE.
- Accepted beat: a valid beat with sop in S_IDLE/S_GAP/S_LINE, or any valid beat in S_LINE.
- col_cnt:
  - Set to 0 on an accepted sop beat.
  - Incremented on each accepted beat; 16 bits wide.
  - Column parity = col_cnt[0] at the accepted beat; sop beat = column 0.
- line_cnt:
  - Increments on each accepted eop.
  - A sop received in S_LINE aborts the current line; this also increments line_cnt, and the new line starts at column 0.
  - On the increment from FRAME_LINES-1, line_cnt wraps to 0.
  - Line parity = line_cnt[0].
- Sample select by (line parity, column parity) per BAYER_PATTERN. For RGGB: (0,0)=R, (0,1)=G, (1,0)=G, (1,1)=B. Other patterns follow the parameter mapping.
- Data is passed through untouched; no arithmetic or rounding.
- sop_err: pulses with the output beat of a sop received in S_LINE. That beat is still output with raw_sop=1.
- eop_err: pulses on rgb_valid&rgb_eop&!rgb_sop in S_IDLE/S_GAP. The beat is dropped.
- len_err: pulses with the output eop beat when col_cnt+1 != LINE_PIXELS at that beat.
- Aborted lines (sop_err) do not additionally raise len_err.
- Errors are reported one cycle after the offending input, aligned with the corresponding output beat.
- Asynchronous reset mid-line takes effect immediately:
  - All outputs clear in the same cycle.
  - After release, the block resumes in S_IDLE and waits for the next sop at line_cnt 0.

Optional Feature:
Macro RGB2RAW_ERR_CNT_EN.
- Defined: err_cnt is a 16-bit saturating counter (holds at 16'hFFFF).
  - Increments by 1 per cycle in which any of sop_err/eop_err/len_err is asserted, even if several are asserted together.
  - Cleared only by reset.
- Undefined: err_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- RGGB, LINE_PIXELS=4, FRAME_LINES=2. Two lines of pixels r=10+i, g=20+i, b=30+i (i = pixel index within the line) -> line0 raw=10,21,12,23; line1 raw=20,31,22,33. raw_sop/raw_eop follow the input exactly 1 clk later; no error pulses.
- BAYER_PATTERN=3 (BGGR), same stimulus -> line0 raw=30,21,32,23; line1 raw=20,11,22,13.
- Frame wrap: send three 4-pixel lines with FRAME_LINES=2 -> the third line uses the line0 pattern again (R,G,R,G).
- Short line: 3 pixels with sop..eop, LINE_PIXELS=4 -> 3 output beats, len_err pulses with the eop beat. Next line pattern uses the odd-line phase.
- Protocol errors, each checked against its own one-cycle pulse:
  - sop at pixel 2 of a line -> sop_err pulse.
  - The new line restarts at column 0 and takes the next line's parity.
  - An isolated valid eop in S_GAP -> eop_err pulse and no raw_valid.
  - A valid beat without sop in S_IDLE -> dropped.
- Reset mid-line, then a clean line -> outputs read 0 during reset; the first line after release uses the line0 pattern. With RGB2RAW_ERR_CNT_EN, err_cnt counts the preceding errors and returns to 0 on reset.

Source files
------------

// File: rtl/rgb2raw_bayer_mosaic_if.sv
// rgb2raw_bayer_mosaic_if: RGB line stream in, Bayer raw line stream plus error flags out
interface rgb2raw_bayer_mosaic_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] r_data;
   logic [DATA_WIDTH-1:0] g_data;
   logic [DATA_WIDTH-1:0] b_data;
   logic                  rgb_valid;
   logic                  rgb_sop;
   logic                  rgb_eop;
   logic [DATA_WIDTH-1:0] raw_data;
   logic                  raw_valid;
   logic                  raw_sop;
   logic                  raw_eop;
   logic                  sop_err;
   logic                  eop_err;
   logic                  len_err;
   logic [15:0]           err_cnt;
   modport master (
      output r_data, g_data, b_data, rgb_valid, rgb_sop, rgb_eop,
      input  raw_data, raw_valid, raw_sop, raw_eop, sop_err, eop_err, len_err, err_cnt
   );
   modport slave (
      input  r_data, g_data, b_data, rgb_valid, rgb_sop, rgb_eop,
      output raw_data, raw_valid, raw_sop, raw_eop, sop_err, eop_err, len_err, err_cnt
   );
endinterface

// File: rtl/rgb2raw_bayer_mosaic.sv
// rgb2raw_bayer_mosaic: re-mosaics RGB lines into a Bayer raw stream; RGB2RAW_ERR_CNT_EN adds a saturating error counter
module rgb2raw_bayer_mosaic #(
   parameter int DATA_WIDTH    = 8,
   parameter int LINE_PIXELS   = 1280,
   parameter int FRAME_LINES   = 720,
   parameter int BAYER_PATTERN = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   rgb2raw_bayer_mosaic_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_LINE, S_GAP} state_t;
   localparam logic [15:0] LAST_LINE = 16'(FRAME_LINES - 1);
   localparam logic [15:0] LINE_LEN  = 16'(LINE_PIXELS);
   state_t                state;
   logic [15:0]           col_cnt;
   logic [15:0]           line_cnt;
   logic                  in_line;
   logic                  sop_v;
   logic                  eop_v;
   logic                  accept;
   logic                  abort;
   logic                  eop_bad;
   logic                  len_bad;
   logic [15:0]           col_eff;
   logic [15:0]           line_eff;
   logic [15:0]           line_nxt;
   logic [1:0]            phase;
   logic [DATA_WIDTH-1:0] sample;
   function automatic logic [15:0] line_inc(input logic [15:0] l);
      return (l == LAST_LINE) ? 16'd0 : l + 16'd1;
   endfunction
   // An abort advances the line before the new sop beat, so that beat already sees the next line's parity.
   always_comb begin
      in_line  = state == S_LINE;
      sop_v    = bus.rgb_valid & bus.rgb_sop;
      eop_v    = bus.rgb_valid & bus.rgb_eop;
      accept   = sop_v | (bus.rgb_valid & in_line);
      abort    = sop_v & in_line;
      col_eff  = sop_v ? 16'd0 : col_cnt;
      line_eff = abort ? line_inc(line_cnt) : line_cnt;
      line_nxt = eop_v ? line_inc(line_eff) : line_eff;
      eop_bad  = eop_v & ~sop_v & ~in_line;
      len_bad  = accept & eop_v & (col_eff + 16'd1 != LINE_LEN);
      // Every pattern is RGGB with the (line, column) phase flipped by the pattern code.
      phase    = {line_eff[0], col_eff[0]} ^ 2'(BAYER_PATTERN);
      sample   = (phase == 2'd0) ? bus.r_data : (phase == 2'd3) ? bus.b_data : bus.g_data;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         col_cnt       <= '0;
         line_cnt      <= '0;
         bus.raw_data  <= '0;
         bus.raw_valid <= 1'b0;
         bus.raw_sop   <= 1'b0;
         bus.raw_eop   <= 1'b0;
         bus.sop_err   <= 1'b0;
         bus.eop_err   <= 1'b0;
         bus.len_err   <= 1'b0;
      end else begin
         state         <= sop_v ? (bus.rgb_eop ? S_GAP : S_LINE) : (in_line & eop_v) ? S_GAP : state;
         if (accept) begin
            col_cnt  <= col_eff + 16'd1;
            line_cnt <= line_nxt;
         end
         bus.raw_data  <= accept ? sample : '0;
         bus.raw_valid <= accept;
         bus.raw_sop   <= sop_v;
         bus.raw_eop   <= accept & eop_v;
         bus.sop_err   <= abort;
         bus.eop_err   <= eop_bad;
         bus.len_err   <= len_bad;
      end
   end
`ifdef RGB2RAW_ERR_CNT_EN
   logic [15:0] err_cnt_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         err_cnt_q <= '0;
      else if ((abort | eop_bad | len_bad) && err_cnt_q != 16'hFFFF)
         err_cnt_q <= err_cnt_q + 16'd1;
   end
   assign bus.err_cnt = err_cnt_q;
`else
   assign bus.err_cnt = '0;
`endif
endmodule

// File: tb/tb_rgb2raw_bayer_mosaic.sv
// tb_rgb2raw_bayer_mosaic: RGGB and BGGR instances fed the same stream, checked against an expected-beat queue
module tb_rgb2raw_bayer_mosaic;
   typedef struct packed {
      logic       v;
      logic       s;
      logic       e;
      logic       se;
      logic       ee;
      logic       le;
      logic [7:0] d0;
      logic [7:0] d3;
   } beat_t;
   logic        clk = 1'b0;
   logic        reset_n;
   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_cnt = '0;
   beat_t       exp_q[$];
   beat_t       obs_q[$];
   always #5 clk = ~clk;
   rgb2raw_bayer_mosaic_if #(.DATA_WIDTH(8)) b0();
   rgb2raw_bayer_mosaic_if #(.DATA_WIDTH(8)) b3();
   assign b3.r_data    = b0.r_data;
   assign b3.g_data    = b0.g_data;
   assign b3.b_data    = b0.b_data;
   assign b3.rgb_valid = b0.rgb_valid;
   assign b3.rgb_sop   = b0.rgb_sop;
   assign b3.rgb_eop   = b0.rgb_eop;
   rgb2raw_bayer_mosaic #(.DATA_WIDTH(8), .LINE_PIXELS(4), .FRAME_LINES(2), .BAYER_PATTERN(0)) u_rggb (
      .clk(clk), .reset_n(reset_n), .bus(b0.slave)
   );
   rgb2raw_bayer_mosaic #(.DATA_WIDTH(8), .LINE_PIXELS(4), .FRAME_LINES(2), .BAYER_PATTERN(3)) u_bggr (
      .clk(clk), .reset_n(reset_n), .bus(b3.slave)
   );
   function automatic logic [7:0] exp_sample(input bit bggr, input bit lp, input bit cp,
                                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      if (lp != cp) return g;
      return ((lp == 1'b0) != bggr) ? r : b;
   endfunction
   task automatic idle_inputs;
      b0.rgb_valid = 1'b0;
      b0.rgb_sop   = 1'b0;
      b0.rgb_eop   = 1'b0;
      b0.r_data    = '0;
      b0.g_data    = '0;
      b0.b_data    = '0;
   endtask
   // One input beat: drive on the falling edge, record the registered result just after the rising edge.
   task automatic tick(input logic v, input logic s, input logic e, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic ev, input logic ese, input logic eee, input logic ele,
                       input bit lp, input bit cp);
      beat_t x;
      beat_t o;
      @(negedge clk);
      b0.rgb_valid = v;
      b0.rgb_sop   = s;
      b0.rgb_eop   = e;
      b0.r_data    = r;
      b0.g_data    = g;
      b0.b_data    = b;
      x = {ev, ev & s, ev & e, ese, eee, ele,
           ev ? exp_sample(1'b0, lp, cp, r, g, b) : 8'd0,
           ev ? exp_sample(1'b1, lp, cp, r, g, b) : 8'd0};
      exp_q.push_back(x);
`ifdef RGB2RAW_ERR_CNT_EN
      if (ese | eee | ele) exp_cnt = exp_cnt + 16'd1;
`endif
      @(posedge clk);
      #1;
      o = {b0.raw_valid, b0.raw_sop, b0.raw_eop, b0.sop_err, b0.eop_err, b0.len_err,
           b0.raw_valid ? b0.raw_data : 8'd0, b3.raw_valid ? b3.raw_data : 8'd0};
      obs_q.push_back(o);
      idle_inputs();
   endtask
   task automatic send_line(input int n, input bit lp);
      for (int i = 0; i < n; i++)
         tick(1'b1, i == 0, i == n - 1, 8'(10 + i), 8'(20 + i), 8'(30 + i),
              1'b1, 1'b0, 1'b0, (i == n - 1) && (n != 4), lp, i[0]);
   endtask
   task automatic test_reset;
      reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({b0.raw_valid, b0.raw_sop, b0.raw_eop, b0.sop_err, b0.eop_err, b0.len_err, b0.raw_data, b3.raw_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got v%b s%b e%b se%b ee%b le%b d0=%h d3=%h, expected all 0", b0.raw_valid,
                  b0.raw_sop, b0.raw_eop, b0.sop_err, b0.eop_err, b0.len_err, b0.raw_data, b3.raw_data);
      end
      checks++;
      if (b0.err_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_err_cnt: got %h expected 0000", b0.err_cnt);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask
   task automatic test_patterns;
      send_line(4, 1'b0);
      send_line(4, 1'b1);
      for (int k = 0; exp_q.size() > 0; k++) begin
         beat_t x = exp_q.pop_front();
         beat_t o = obs_q.pop_front();
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL patterns beat %0d: got %h expected %h", k, o, x);
         end
      end
   endtask
   task automatic test_frame_wrap;
      send_line(4, 1'b0);
      send_line(4, 1'b1);
      send_line(4, 1'b0);
      for (int k = 0; exp_q.size() > 0; k++) begin
         beat_t x = exp_q.pop_front();
         beat_t o = obs_q.pop_front();
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL frame_wrap beat %0d: got %h expected %h", k, o, x);
         end
      end
   endtask
   task automatic test_short_line;
      send_line(4, 1'b1);
      send_line(3, 1'b0);
      send_line(4, 1'b1);
      for (int k = 0; exp_q.size() > 0; k++) begin
         beat_t x = exp_q.pop_front();
         beat_t o = obs_q.pop_front();
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL short_line beat %0d: got %h expected %h", k, o, x);
         end
      end
   endtask
   task automatic test_protocol;
      tick(1'b1, 1'b1, 1'b0, 8'd40, 8'd50, 8'd60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 8'd41, 8'd51, 8'd61, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0, 8'd42, 8'd52, 8'd62, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 8'd43, 8'd53, 8'd63, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b1, 1'b0, 1'b0, 8'd44, 8'd54, 8'd64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 8'd45, 8'd55, 8'd65, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick(1'b1, 1'b0, 1'b1, 8'd46, 8'd56, 8'd66, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; exp_q.size() > 0; k++) begin
         beat_t x = exp_q.pop_front();
         beat_t o = obs_q.pop_front();
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL protocol beat %0d: got %h expected %h", k, o, x);
         end
      end
      checks++;
      if (b0.err_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL protocol_err_cnt: got %h expected %h", b0.err_cnt, exp_cnt);
      end
   endtask
   task automatic test_reset_midline;
      tick(1'b1, 1'b1, 1'b0, 8'd70, 8'd80, 8'd90, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0, 8'd71, 8'd81, 8'd91, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      b0.rgb_valid = 1'b1;
      b0.r_data    = 8'd72;
      #2;
      reset_n = 1'b0;
      exp_cnt = '0;
      #1;
      checks++;
      if ({b0.raw_valid, b0.raw_sop, b0.raw_eop, b0.sop_err, b0.eop_err, b0.len_err, b0.raw_data, b3.raw_data} !== '0) begin
         errors++;
         $display("FAIL midline_reset_outputs: got v%b d0=%h d3=%h, expected all 0", b0.raw_valid, b0.raw_data, b3.raw_data);
      end
      checks++;
      if (b0.err_cnt !== 16'd0) begin
         errors++;
         $display("FAIL midline_reset_err_cnt: got %h expected 0000", b0.err_cnt);
      end
      idle_inputs();
      @(negedge clk);
      reset_n = 1'b1;
      tick(1'b1, 1'b0, 1'b0, 8'd99, 8'd98, 8'd97, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_line(4, 1'b0);
      for (int k = 0; exp_q.size() > 0; k++) begin
         beat_t x = exp_q.pop_front();
         beat_t o = obs_q.pop_front();
         checks++;
         if (o !== x) begin
            errors++;
            $display("FAIL reset_midline beat %0d: got %h expected %h", k, o, x);
         end
      end
      checks++;
      if (b0.err_cnt !== 16'd0) begin
         errors++;
         $display("FAIL post_reset_err_cnt: got %h expected 0000", b0.err_cnt);
      end
   endtask
   initial begin
      test_reset();
      test_patterns();
      test_frame_wrap();
      test_short_line();
      test_protocol();
      test_reset_midline();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
